// File: rtl/dftprobe_scan_ctrl.sv
// Sequencer for the DFT probe cells: walks the probe enables one at a time with
// break-before-make gaps, captures each tdi return and flags a masked mismatch.
module dftprobe_scan_ctrl #(
    parameter int NPROBE = 8,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NPROBE-1:0] mask,
    input  logic [NPROBE-1:0] expected,
    input  logic [NPROBE-1:0] tdi,
    output logic [NPROBE-1:0] ten,
    output logic [NPROBE-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              fail,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              CELSUB
);

    localparam int IDX_W = (NPROBE > 1) ? $clog2(NPROBE) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPROBE - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, PROBE, GAP, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NPROBE-1:0] mask_q_reg, mask_q_next;
    logic [NPROBE-1:0] exp_q_reg, exp_q_next;
    logic [NPROBE-1:0] result_reg, result_next;
    logic              fail_reg, fail_next;
    logic [NPROBE-1:0] ten_reg, ten_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    // Supply/ground/substrate pins only pass through the cell boundary.
    logic unused_supply;
    assign unused_supply = ^{CELV, CELG, CELSUB};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            mask_q_reg <= '0;
            exp_q_reg  <= '0;
            result_reg <= '0;
            fail_reg   <= 1'b0;
            ten_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            mask_q_reg <= mask_q_next;
            exp_q_reg  <= exp_q_next;
            result_reg <= result_next;
            fail_reg   <= fail_next;
            ten_reg    <= ten_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        mask_q_next = mask_q_reg;
        exp_q_next  = exp_q_reg;
        result_next = result_reg;
        fail_next   = fail_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = PROBE;
                    mask_q_next = mask;
                    exp_q_next  = expected;
                    result_next = '0;
                    fail_next   = 1'b0;
                    idx_next    = '0;
                    cnt_next    = '0;
                end
            end
            PROBE: begin
                // Abort wins over a capture falling on the same edge.
                if (abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (!mask_q_reg[idx_reg]) begin
                    state_next = GAP;
                end else if (cnt_reg == LAST_CNT) begin
                    result_next[idx_reg] = tdi[idx_reg];
                    state_next           = GAP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            GAP: begin
                cnt_next = '0;
                if (abort) begin
                    state_next = IDLE;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                    fail_next  = |((result_reg ^ exp_q_reg) & mask_q_reg);
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = PROBE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        busy_next = (state_next == PROBE) || (state_next == GAP);
        done_next = (state_next == DONE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPROBE; gi++) begin : g_ten
            assign ten_next[gi] = (state_next == PROBE) && mask_q_next[gi] &&
                                  (idx_next == IDX_W'(gi));
        end
    endgenerate

    assign ten    = ten_reg;
    assign result = result_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign fail   = fail_reg;

endmodule

// File: tb/tb_dftprobe_scan_ctrl.sv
// Scoreboard bench for dftprobe_scan_ctrl (NPROBE=4, SETTLE=4): a timing model
// predicts ten/busy/done every cycle, queued results are compared on done.
module tb_dftprobe_scan_ctrl;

    localparam int NP = 4;
    localparam int ST = 4;
    localparam int NO_ABORT = 1000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NP-1:0] mask = '0;
    logic [NP-1:0] expected = '0;
    logic [NP-1:0] tdi = '0;
    logic [NP-1:0] ten;
    logic [NP-1:0] result;
    logic          busy;
    logic          done;
    logic          fail;

    typedef struct {
        int            e0;
        logic [NP-1:0] m;
        int            abort_k;
        logic [NP-1:0] res;
        logic          fl;
        int            ncyc;
    } run_t;

    run_t runs[$];
    run_t sb[$];

    int n_vec = 0;
    int n_miss = 0;
    int edge_cnt = 0;
    bit mon_en = 1'b0;

    dftprobe_scan_ctrl #(.NPROBE(NP), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mask(mask), .expected(expected), .tdi(tdi),
        .ten(ten), .result(result), .busy(busy), .done(done), .fail(fail),
        .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int scan_len(input logic [NP-1:0] m);
        int n = 0;
        for (int i = 0; i < NP; i++) n += m[i] ? ST + 1 : 2;
        return n;
    endfunction

    // Expected ten/busy/done in cycle k (k=1 is the first cycle after the start edge).
    function automatic void model(input run_t r, input int k, output logic [NP-1:0] et,
                                  output logic eb, output logic ed);
        int pos = 1;
        et = '0;
        for (int i = 0; i < NP; i++) begin
            if (r.m[i]) begin
                if (k >= pos && k < pos + ST) et[i] = 1'b1;
                pos += ST + 1;
            end else begin
                pos += 2;
            end
        end
        eb = (k >= 1) && (k <= pos - 1);
        ed = (k == pos);
        if (k > r.abort_k) begin
            et = '0;
            eb = 1'b0;
            ed = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            run_t          cur;
            run_t          ent;
            bit            have = 1'b0;
            logic [NP-1:0] et = '0;
            logic          eb = 1'b0;
            logic          ed = 1'b0;
            for (int i = runs.size() - 1; i >= 0; i--) begin
                if (runs[i].e0 <= edge_cnt) begin
                    cur  = runs[i];
                    have = 1'b1;
                    break;
                end
            end
            if (have) model(cur, edge_cnt - cur.e0 + 1, et, eb, ed);
            check("ten", ten, et);
            check("busy", busy, eb);
            check("done", done, ed);
            if (done === 1'b1 && sb.size() > 0) begin
                ent = sb.pop_front();
                $display("scan e0=%0d mask=%b: result=%b fail=%b", ent.e0, ent.m, result, fail);
                check("result", result, ent.res);
                check("fail", fail, ent.fl);
                check("done_cycle", edge_cnt - ent.e0 + 1, ent.ncyc);
            end
        end
    end

    task automatic push_run(input int e0, input logic [NP-1:0] m, input logic [NP-1:0] e,
                            input logic [NP-1:0] res, input int ak);
        run_t r;
        r.e0      = e0;
        r.m       = m;
        r.abort_k = ak;
        r.res     = res;
        r.fl      = |((res ^ e) & m);
        r.ncyc    = scan_len(m) + 1;
        runs.push_back(r);
        if (ak > scan_len(m)) sb.push_back(r);
    endtask

    task automatic start_scan(input logic [NP-1:0] m, input logic [NP-1:0] e,
                              input logic [NP-1:0] d, input logic [NP-1:0] res,
                              input int ak, input bit hold, input bit ab, output int e0);
        @(negedge clk);
        mask     = m;
        expected = e;
        tdi      = d;
        start    = 1'b1;
        abort    = ab;
        e0       = edge_cnt + 1;
        push_run(e0, m, e, res, ak);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    task automatic wait_cycle(input int e0, input int k);
        while (edge_cnt < e0 + k - 1) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e0;
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ten", ten, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_fail", fail, 0);
        mon_en = 1'b1;

        // Full scan, all probes enabled, matching.
        start_scan(4'b1111, 4'b1010, 4'b1010, 4'b1010, NO_ABORT, 1'b0, 1'b0, e0);
        wait_idle();

        // Masked scan: bit 2 mismatches; bits 1/3 are set on tdi but not visited.
        start_scan(4'b0101, 4'b0001, 4'b1111, 4'b0101, NO_ABORT, 1'b0, 1'b0, e0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("fail_hold", fail, 1);

        // Mismatches confined to masked-out bits do not fail.
        start_scan(4'b0101, 4'b1111, 4'b1111, 4'b0101, NO_ABORT, 1'b0, 1'b0, e0);
        wait_idle();

        // Reset two cycles in the middle of a scan.
        start_scan(4'b1111, 4'b1010, 4'b1010, 4'b1010, 7, 1'b0, 1'b0, e0);
        wait_cycle(e0, 7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ten", ten, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_fail", fail, 0);
        repeat (25) @(negedge clk);

        // Late settle: tdi[1] rises in the last cycle of its window, then one cycle later.
        start_scan(4'b1111, 4'b0010, 4'b0000, 4'b0010, NO_ABORT, 1'b0, 1'b0, e0);
        wait_cycle(e0, 9);
        tdi[1] = 1'b1;
        wait_idle();
        tdi = '0;
        start_scan(4'b1111, 4'b0010, 4'b0000, 4'b0000, NO_ABORT, 1'b0, 1'b0, e0);
        wait_cycle(e0, 10);
        tdi[1] = 1'b1;
        wait_idle();
        tdi = '0;

        // Abort during PROBE of idx 2.
        start_scan(4'b1111, 4'b1011, 4'b1011, 4'b1011, 12, 1'b0, 1'b0, e0);
        wait_cycle(e0, 12);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_result", result, 4'b0011);
        check("abort_fail", fail, 0);
        repeat (20) @(negedge clk);

        // Start with abort also high in IDLE is accepted.
        start_scan(4'b0011, 4'b0001, 4'b0011, 4'b0011, NO_ABORT, 1'b0, 1'b1, e0);
        wait_idle();

        // Start held high: one scan, then the next begins right after DONE.
        start_scan(4'b1111, 4'b0110, 4'b0110, 4'b0110, NO_ABORT, 1'b1, 1'b0, e0);
        push_run(e0 + scan_len(4'b1111) + 2, 4'b1111, 4'b0110, 4'b0110, NO_ABORT);
        wait_cycle(e0 + scan_len(4'b1111) + 2, 2);
        start = 1'b0;
        wait_idle();

        // Empty mask: only gap/probe slots, no enables.
        start_scan(4'b0000, 4'b1111, 4'b1111, 4'b0000, NO_ABORT, 1'b0, 1'b0, e0);
        wait_idle();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dftprobe_scan_ctrl.md
# dftprobe_scan_ctrl

Sequencer for the DFT probe cells on the stepdown/powergood observation points. It drives the per-probe `ten` enables one at a time with break-before-make spacing, waits a programmable settle time, and captures each probe's `tdi` return into a parallel result register. It compares the masked result against an expected vector and reports pass/fail on completion. It sits between the test controller (start/abort/mask/expect) and the array of DFTtdi probe wrappers.

## Interface

**Parameters**
- `NPROBE`, default 8: number of probe points; legal range 1..32.
- `SETTLE`, default 4: cycles `ten` is held high before capture; minimum 1.

**Ports**
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a scan; sampled only in IDLE.
- `abort`  in  1: terminate an in-progress scan.
- `mask`  in  NPROBE: probes to visit; latched on accepted start.
- `expect`  in  NPROBE: expected probe values; latched on accepted start.
- `tdi`  in  NPROBE: returns from the probe cells.
- `ten`  out  NPROBE: probe test enables; at most one bit high.
- `result`  out  NPROBE: captured probe values.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle completion pulse.
- `fail`  out  1: mismatch flag; valid with `done` and held until the next accepted start.
- `CELV`, `CELG`, `CELSUB`  in  1 each: supply, ground and substrate pass-through. No logical function.

## Operation

**States:** IDLE, PROBE, GAP, DONE. Internal state is `idx` (width clog2(NPROBE), min 1), `cnt` (width clog2(SETTLE+1)), `mask_q` and `exp_q`.

**Reset:** state=IDLE, `ten`=0, `result`=0, `busy`=0, `done`=0, `fail`=0, `idx`=0, `cnt`=0. Reset mid-scan drops `ten` on the next edge.

**IDLE**
- `ten`=0, `busy`=0.
- When `start`=1, on that edge:
  - latch `mask_q`←`mask` and `exp_q`←`expect`;
  - clear `result` and `fail`;
  - set `idx`=0 and `cnt`=0;
  - go to PROBE.

**PROBE**
- `ten` = one-hot(`idx`) if `mask_q[idx]`, else 0.
- Masked-out probe: lasts exactly 1 cycle; `result[idx]` stays 0; then GAP.
- Enabled probe: lasts exactly SETTLE cycles, with `cnt` counting 0..SETTLE-1.
  - On the edge where `cnt`==SETTLE-1: `result[idx]`←`tdi[idx]`, then GAP.

**GAP**
- 1 cycle, `ten`=0 (break-before-make). Resets `cnt`.
- If `idx`==NPROBE-1, go to DONE; else `idx`++ and go to PROBE.

**DONE**
- 1 cycle: `done`=1, `busy`=0.
- `fail` = |((`result` ^ `exp_q`) & `mask_q`), registered so that it is valid in the DONE cycle.
- Then IDLE.

**Control rules**
- `busy`=1 in PROBE and GAP only.
- `abort`=1 in PROBE or GAP: next state is IDLE and `ten`=0 on that edge.
  - No `done` pulse; `fail` is unchanged (0).
  - `result` keeps the bits already captured.
  - `abort` has priority over capture on the same edge.
- `abort` in IDLE or DONE: ignored.
- `start` outside IDLE: ignored, including in the DONE cycle.
- `start` and `abort` both high in IDLE: the start is accepted.
- `mask`=0: the scan runs all GAP/PROBE slots at 2 cycles each with no `ten` activity; `fail`=0.

## Timing

- All outputs are registered; `ten` changes only on clock edges.
- Start accepted at edge E0: the first PROBE cycle follows E0, and `busy` is high from the cycle after E0.
- Per-probe cost: SETTLE+1 cycles if enabled, 2 cycles if masked.
- DONE cycle index after E0 = 1 + Σ cost. Example: NPROBE=4, SETTLE=4, mask=0101 gives 5+2+5+2=14 cycles, and `done` is high in cycle 15.
- `tdi[idx]` is sampled on the final edge of its PROBE window, i.e. after `ten[idx]` has been high for SETTLE cycles.
- No two `ten` bits are ever high in the same cycle. There is at least one all-zero cycle between consecutive enables.
- Back-to-back scans: `start` in the cycle after DONE is accepted (minimum 1 IDLE cycle).

## Test plan

- **Reset:** assert `rst` for 2 cycles mid-scan → next cycle `ten`=0, `busy`=0, `done`=0, `result`=0, `fail`=0.
- **Full scan, pass:** NPROBE=4, SETTLE=4, mask=1111, `tdi`=1010, expect=1010 → each `ten` bit high for 4 cycles with 1-cycle gaps; `done` in cycle 21; `result`=1010; `fail`=0.
- **Masked scan, fail:** mask=0101, `tdi`=1111, expect=0001 → only `ten[0]` and `ten[2]` pulse; `done` in cycle 15; `result`=0101; `fail`=1. A mismatch on masked bits 1 and 3 alone does not set `fail`.
- **Late settle:** `tdi[1]` toggles 0→1 on the last cycle of its window → `result[1]`=1. A toggle one cycle after the window → `result[1]`=0.
- **Abort:** pulse `abort` during PROBE of idx 2 with mask=1111 → `ten`=0 on the next edge, state IDLE, no `done`, `result[1:0]` retained and `result[3:2]`=0. A new `start` is then accepted normally.
- **Protocol edges:** `start` held high throughout a scan → exactly one scan runs, then the next scan starts the cycle after DONE. `mask`=0000 → `done` in cycle 9 with `ten` never asserted and `fail`=0.
